// File: rtl/file_register_pkg.sv
// Shared definitions for the file_register_param register file.
// Contents: default width/depth constants and the sweep-clear FSM state encoding.
package file_register_pkg;

  localparam int unsigned DEFAULT_DATA_W = 32;
  localparam int unsigned DEFAULT_ADDR_W = 5;

  typedef enum logic {
    StIdle  = 1'b0,
    StClear = 1'b1
  } clear_state_e;

endpackage

// File: rtl/file_register_clear_fsm.sv
// Sweep-clear controller for the register file.
// Holds the IDLE/CLEAR state, the sweep address counter, clear_busy and write_drop.
// Ports:
//   clk, rst_all   - clock, asynchronous active-low reset
//   clear_req      - start a sweep (ignored while sweeping)
//   we             - write enable seen by the storage, used to flag dropped writes
//   clear_busy     - registered, high for exactly 2**ADDR_W cycles per sweep
//   clear_addr     - entry zeroed on the current edge while clear_busy is high
//   write_drop     - one-cycle pulse after a write rejected during a sweep
module file_register_clear_fsm
  import file_register_pkg::*;
#(
  parameter int unsigned ADDR_W = DEFAULT_ADDR_W
) (
  input  logic              clk,
  input  logic              rst_all,
  input  logic              clear_req,
  input  logic              we,
  output logic              clear_busy,
  output logic [ADDR_W-1:0] clear_addr,
  output logic              write_drop
);

  clear_state_e      state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic              drop_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (clear_req) begin
          state_d = StClear;
          cnt_d   = '0;
        end
      end
      StClear: begin
        // Counter wraps back to 0 as the last entry is swept.
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == {ADDR_W{1'b1}}) begin
          state_d = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_all) begin
    if (!rst_all) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      drop_q  <= we && (state_q == StClear);
    end
  end

  assign clear_busy = (state_q == StClear);
  assign clear_addr = cnt_q;
  assign write_drop = drop_q;

endmodule

// File: rtl/file_register_param.sv
// Parameterised register file: one byte-enabled write port, two combinational
// read ports, optional hardwired-zero entry 0, and a one-entry-per-cycle sweep clear.
// Optional feature: define BYPASS_EN to forward an in-flight write to a read of
// the same entry before the clock edge.
// Ports:
//   clk, rst_all                      - clock, asynchronous active-low reset
//   we, write_be, write_addr, write_data - write port
//   read0_addr/read0_data, read1_addr/read1_data - combinational read ports
//   clear_req, clear_busy             - sweep request / sweep in progress
//   write_drop                        - pulse after a write rejected by a sweep
module file_register_param
  import file_register_pkg::*;
#(
  parameter int unsigned DATA_W   = DEFAULT_DATA_W,
  parameter int unsigned ADDR_W   = DEFAULT_ADDR_W,
  parameter int unsigned ZERO_REG = 1
) (
  input  logic                clk,
  input  logic                rst_all,
  input  logic                we,
  input  logic [DATA_W/8-1:0] write_be,
  input  logic [ADDR_W-1:0]   write_addr,
  input  logic [DATA_W-1:0]   write_data,
  input  logic [ADDR_W-1:0]   read0_addr,
  output logic [DATA_W-1:0]   read0_data,
  input  logic [ADDR_W-1:0]   read1_addr,
  output logic [DATA_W-1:0]   read1_data,
  input  logic                clear_req,
  output logic                clear_busy,
  output logic                write_drop
);

  localparam int unsigned Depth = 2 ** ADDR_W;
  localparam int unsigned NumBytes = DATA_W / 8;

  logic [DATA_W-1:0] mem_q [Depth];
  logic [ADDR_W-1:0] clear_addr;
  logic              wr_zero_entry;
  logic              wr_en;
  logic [DATA_W-1:0] wr_merged;

  file_register_clear_fsm #(
    .ADDR_W (ADDR_W)
  ) u_clear_fsm (
    .clk        (clk),
    .rst_all    (rst_all),
    .clear_req  (clear_req),
    .we         (we),
    .clear_busy (clear_busy),
    .clear_addr (clear_addr),
    .write_drop (write_drop)
  );

  // Writes to a hardwired-zero entry are silently discarded, not counted as drops.
  assign wr_zero_entry = (ZERO_REG != 0) && (write_addr == '0);
  assign wr_en         = we && !clear_busy && !wr_zero_entry;

  always_comb begin
    wr_merged = mem_q[write_addr];
    for (int b = 0; b < NumBytes; b++) begin
      if (write_be[b]) begin
        wr_merged[8*b +: 8] = write_data[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_all) begin
    if (!rst_all) begin
      for (int i = 0; i < Depth; i++) begin
        mem_q[i] <= '0;
      end
    end else if (clear_busy) begin
      mem_q[clear_addr] <= '0;
    end else if (wr_en) begin
      mem_q[write_addr] <= wr_merged;
    end
  end

  always_comb begin
    read0_data = mem_q[read0_addr];
    read1_data = mem_q[read1_addr];
`ifdef BYPASS_EN
    if (wr_en && (read0_addr == write_addr)) read0_data = wr_merged;
    if (wr_en && (read1_addr == write_addr)) read1_data = wr_merged;
`endif
    if ((ZERO_REG != 0) && (read0_addr == '0)) read0_data = '0;
    if ((ZERO_REG != 0) && (read1_addr == '0)) read1_data = '0;
  end

endmodule

// File: tb/tb_file_register_param.sv
// Self-checking bench for file_register_param (default parameters: 32-bit, 32 entries,
// entry 0 hardwired to zero). Honours BYPASS_EN when defined for the whole build.
module tb_file_register_param;

  logic        clk = 1'b0;
  logic        rst_all;
  logic        we;
  logic [3:0]  write_be;
  logic [4:0]  write_addr;
  logic [31:0] write_data;
  logic [4:0]  read0_addr;
  logic [31:0] read0_data;
  logic [4:0]  read1_addr;
  logic [31:0] read1_data;
  logic        clear_req;
  logic        clear_busy;
  logic        write_drop;

  int checks = 0;
  int failures = 0;

  file_register_param dut (
    .clk        (clk),
    .rst_all    (rst_all),
    .we         (we),
    .write_be   (write_be),
    .write_addr (write_addr),
    .write_data (write_data),
    .read0_addr (read0_addr),
    .read0_data (read0_data),
    .read1_addr (read1_addr),
    .read1_data (read1_data),
    .clear_req  (clear_req),
    .clear_busy (clear_busy),
    .write_drop (write_drop)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  be;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic [4:0]  r0addr;
    logic [4:0]  r1addr;
    logic [31:0] exp_r0;
    logic [31:0] exp_r1;
  } vec_t;

  vec_t vecs [6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [31:0] exp_bypass;
  int          busy_cnt;
  bit          all_zero;

  initial begin
    vecs[0] = '{4'hF, 5'd1,  32'h5ADFACED, 5'd1,  5'd2,  32'h5ADFACED, 32'h0};
    vecs[1] = '{4'h5, 5'd21, 32'hEA770A57, 5'd1,  5'd21, 32'h5ADFACED, 32'h00770057};
    vecs[2] = '{4'hF, 5'd0,  32'hFFFFFFFF, 5'd0,  5'd0,  32'h0,        32'h0};
    vecs[3] = '{4'hF, 5'd3,  32'hAAAAAAAA, 5'd3,  5'd21, 32'hAAAAAAAA, 32'h00770057};
    vecs[4] = '{4'hA, 5'd21, 32'h11223344, 5'd3,  5'd21, 32'hAAAAAAAA, 32'h11773357};
    vecs[5] = '{4'h8, 5'd31, 32'hDEADBEEF, 5'd31, 5'd1,  32'hDE000000, 32'h5ADFACED};

    rst_all = 1'b0; we = 1'b0; write_be = '0; write_addr = '0; write_data = '0;
    read0_addr = 5'd1; read1_addr = 5'd21; clear_req = 1'b0;
    #12;
    chk("reset_busy", {31'b0, clear_busy}, 32'h0);
    chk("reset_drop", {31'b0, write_drop}, 32'h0);
    chk("reset_r0", read0_data, 32'h0);
    chk("reset_r1", read1_data, 32'h0);
    rst_all = 1'b1;
    step();

    // Table: write on one edge, then read both ports with write disabled.
    for (int i = 0; i < 6; i++) begin
      we = 1'b1; write_be = vecs[i].be; write_addr = vecs[i].waddr; write_data = vecs[i].wdata;
      step();
      we = 1'b0;
      read0_addr = vecs[i].r0addr; read1_addr = vecs[i].r1addr;
      #1;
      chk($sformatf("vec%0d_r0", i), read0_data, vecs[i].exp_r0);
      chk($sformatf("vec%0d_r1", i), read1_data, vecs[i].exp_r1);
      chk($sformatf("vec%0d_drop", i), {31'b0, write_drop}, 32'h0);
    end

    // Same-cycle write and read of entry 3.
`ifdef BYPASS_EN
    exp_bypass = 32'h12345678;
`else
    exp_bypass = 32'hAAAAAAAA;
`endif
    we = 1'b1; write_be = 4'hF; write_addr = 5'd3; write_data = 32'h12345678; read1_addr = 5'd3;
    #1;
    chk("bypass_pre_edge", read1_data, exp_bypass);
    step();
    we = 1'b0;
    #1;
    chk("bypass_post_edge", read1_data, 32'h12345678);

    // Sweep: one-cycle request, dropped write mid-sweep, ignored re-request.
    clear_req = 1'b1;
    step();
    clear_req = 1'b0;
    busy_cnt = 0;
    while (clear_busy && busy_cnt < 100) begin
      busy_cnt++;
      if (busy_cnt == 3) begin
        we = 1'b1; write_be = 4'hF; write_addr = 5'd5; write_data = 32'h1;
      end
      if (busy_cnt == 4) begin
        read0_addr = 5'd1; read1_addr = 5'd21;
        #1;
        chk("sweep_drop_pulse", {31'b0, write_drop}, 32'h1);
        chk("sweep_swept_r0", read0_data, 32'h0);
        chk("sweep_unswept_r1", read1_data, 32'h11773357);
        we = 1'b0;
      end
      if (busy_cnt == 5) chk("sweep_drop_clear", {31'b0, write_drop}, 32'h0);
      clear_req = (busy_cnt == 10);
      step();
    end
    clear_req = 1'b0;
    chk("sweep_busy_cycles", busy_cnt, 32'd32);
    all_zero = 1'b1;
    for (int a = 0; a < 32; a++) begin
      read0_addr = a[4:0];
      #1;
      if (read0_data !== 32'h0) all_zero = 1'b0;
    end
    chk("sweep_all_zero", {31'b0, all_zero}, 32'h1);
    read1_addr = 5'd5;
    #1;
    chk("sweep_addr5_zero", read1_data, 32'h0);

    // Write and clear request on the same idle edge: write lands, then is swept.
    we = 1'b1; write_be = 4'hF; write_addr = 5'd9; write_data = 32'hCAFEF00D; clear_req = 1'b1;
    step();
    we = 1'b0; clear_req = 1'b0; read0_addr = 5'd9;
    #1;
    chk("simul_write_landed", read0_data, 32'hCAFEF00D);
    busy_cnt = 0;
    while (clear_busy && busy_cnt < 100) begin
      busy_cnt++;
      step();
    end
    chk("simul_busy_cycles", busy_cnt, 32'd32);
    chk("simul_swept", read0_data, 32'h0);

    // Reset in the middle of a sweep.
    we = 1'b1; write_be = 4'hF; write_addr = 5'd30; write_data = 32'h0BADF00D;
    step();
    we = 1'b0; clear_req = 1'b1;
    step();
    clear_req = 1'b0;
    for (int c = 0; c < 10; c++) step();
    rst_all = 1'b0;
    read0_addr = 5'd30;
    #1;
    chk("midrst_busy", {31'b0, clear_busy}, 32'h0);
    chk("midrst_r0", read0_data, 32'h0);
    all_zero = 1'b1;
    for (int a = 0; a < 32; a++) begin
      read1_addr = a[4:0];
      #1;
      if (read1_data !== 32'h0) all_zero = 1'b0;
    end
    chk("midrst_all_zero", {31'b0, all_zero}, 32'h1);
    rst_all = 1'b1;
    step();
    step();
    chk("postrst_busy", {31'b0, clear_busy}, 32'h0);
    chk("postrst_drop", {31'b0, write_drop}, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/file_register_param.md
FILE_REGISTER_PARAM -- requirements
Module: file_register_param

Interface
REQ-001 SHALL have parameter DATA_W, default 32: register width in bits; a multiple of 8.
REQ-002 SHALL have parameter ADDR_W, default 5: address width; DEPTH = 2**ADDR_W entries.
REQ-003 SHALL have parameter ZERO_REG, default 1: when 1, entry 0 is hardwired to zero.
REQ-004 SHALL have port clk  in  1  single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst_all  in  1  asynchronous, active-low reset.
REQ-006 SHALL have port we  in  1  write enable.
REQ-007 SHALL have port write_be  in  DATA_W/8  byte enables; bit k enables byte k.
REQ-008 SHALL have port write_addr  in  ADDR_W  write entry select.
REQ-009 SHALL have port write_data  in  DATA_W  write data.
REQ-010 SHALL have port read0_addr  in  ADDR_W  read port 0 entry select.
REQ-011 SHALL have port read0_data  out  DATA_W  read port 0 data.
REQ-012 SHALL have port read1_addr  in  ADDR_W  read port 1 entry select.
REQ-013 SHALL have port read1_data  out  DATA_W  read port 1 data.
REQ-014 SHALL have port clear_req  in  1  request for a sweep clear of all entries.
REQ-015 SHALL have port clear_busy  out  1  high while the sweep is in progress.
REQ-016 SHALL have port write_drop  out  1  one-cycle pulse when a write is rejected.

Function
REQ-017 SHALL provide combinational reads: readN_data = contents of entry readN_addr, with no clock latency.
REQ-018 SHALL, on a rising edge with we=1 and clear_busy=0, update only the bytes of write_addr whose write_be bit is 1; the other bytes SHALL be unchanged.
REQ-019 SHALL, when ZERO_REG=1, return 0 for reads of entry 0; writes to entry 0 are discarded, and write_drop SHALL NOT assert for them.
REQ-020 SHALL implement a two-state FSM: IDLE and CLEAR; clear_busy = (state == CLEAR), registered.
REQ-021 SHALL transition IDLE->CLEAR on a rising edge with clear_req=1; the sweep counter SHALL start at 0.
REQ-022 SHALL, in CLEAR, zero one entry per cycle at the counter address, increment the counter, and return to IDLE after entry DEPTH-1 is zeroed; clear_busy SHALL be high for exactly DEPTH cycles.
REQ-023 SHALL ignore clear_req while in CLEAR; a sweep is not restarted or extended.
REQ-024 SHALL discard a write while clear_busy=1 and SHALL pulse write_drop high for the following cycle.
REQ-025 SHALL, during CLEAR, serve reads from current contents: already-swept entries read 0, and unswept entries read their old values.
REQ-026 SHALL give the sweep priority when clear_req and we are both high in IDLE on the same edge: the write completes on that edge, and the sweep then zeroes every entry.

Reset
REQ-027 SHALL, while rst_all=0, immediately force all entries to 0, state to IDLE, counter to 0, clear_busy=0, and write_drop=0, regardless of clk.
REQ-028 SHALL, on reset asserted mid-sweep, abort the sweep, with no partial state remaining after reset release.

Configuration
REQ-029 SHALL, with BYPASS_EN defined, forward writes: a read of the entry being written in the same cycle (we=1, clear_busy=0, entry not hardwired zero) SHALL return the byte-merged new value combinationally before the edge.
REQ-030 SHALL, without BYPASS_EN, return the stored pre-edge value in that case; the new value appears after the edge.

Structure
REQ-031 SHALL take the FSM state encoding (IDLE, CLEAR) and the default width and depth constants from shared package file_register_pkg.
REQ-032 SHALL contain one sub-module, file_register_clear_fsm, which holds the state, sweep counter, clear_busy, and write_drop logic; the storage array stays in the top module.

Verification
REQ-033 SHALL test: reset, then write 32'h5ADFACED to addr 1 with be=4'hF -> read0_data=32'h5ADFACED after the edge; read1 of addr 2 = 0.
REQ-034 SHALL test: addr 21 holds 0; write 32'hEA770A57 with be=4'b0101 -> read1_data=32'h00770057.
REQ-035 SHALL test: write 32'hFFFFFFFF to addr 0 with ZERO_REG=1 -> reads return 0, and write_drop stays 0.
REQ-036 SHALL test: DEPTH=32 with addrs 1 and 21 loaded; one-cycle clear_req -> clear_busy high for 32 cycles; a write of 32'h1 to addr 5 during the sweep -> write_drop pulses and addr 5 reads 0; all entries read 0 after the sweep.
REQ-037 SHALL test: addr 3 holds 32'hAAAAAAAA; in the same cycle, write 32'h12345678 to addr 3 and read it on port 1 -> with BYPASS_EN, 32'h12345678 before the edge; without BYPASS_EN, 32'hAAAAAAAA before the edge.
REQ-038 SHALL test: rst_all pulsed low at sweep cycle 10 -> clear_busy=0 immediately and all entries read 0.
